// File: rtl/spram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between requesters A and B,
// with an optional zero-fill sweep of the whole RAM after reset.
module spram_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  init_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic {S_CLEAR, S_ARB} state_t;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_ARB;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_last_gnt_b;
  logic                  r_a_rvalid;
  logic                  r_b_rvalid;
  logic                  w_clr_done;

  assign w_clr_done = (r_clr_cnt == ADDR_WIDTH'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RST_STATE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == S_CLEAR && w_clr_done) w_state_next = S_ARB;
  end

  // Everything RAM-facing is forced low while rst is held, whatever the state register says.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    if (!rst) begin
      case (r_state)
        S_CLEAR: begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = r_clr_cnt;
        end
        default: begin
          a_gnt = a_req && (!b_req || r_last_gnt_b);
          b_gnt = b_req && (!a_req || !r_last_gnt_b);
          if (a_gnt) begin
            ram_en   = 1'b1;
            ram_we   = a_we;
            ram_addr = a_addr;
            ram_din  = a_din;
          end else if (b_gnt) begin
            ram_en   = 1'b1;
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_din  = b_din;
          end
        end
      endcase
    end
  end

  assign init_busy = (r_state == S_CLEAR);

  // Counter parks at DEPTH-1 instead of wrapping; only a reset rewinds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_cnt <= '0;
    end else if (r_state == S_CLEAR && !w_clr_done) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  // Priority only flips on a genuine tie, so the next tie goes to the other side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt_b <= 1'b1;
    end else if (a_req && b_req && (a_gnt || b_gnt)) begin
      r_last_gnt_b <= b_gnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= a_gnt && !a_we;
      r_b_rvalid <= b_gnt && !b_we;
    end
  end

  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rvalid ? ram_dout : '0;
  assign b_rdata  = r_b_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter: behavioural RAM behind the arbiter, shadow memory and
// per-requester read-return queues as the scoreboard.
module tb_spram_arbiter;

  logic       clk;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_din, b_din;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_en, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic       init_busy;

  logic [7:0] mem [16];
  logic [7:0] shadow [16];
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  int n_cmp = 0;
  int n_err = 0;

  spram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .init_busy(init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with registered read
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rv();
    logic [7:0] d;
    if (qa.size() > 0) begin
      d = qa.pop_front();
      chk("a_rvalid", 32'(a_rvalid), 32'd1);
      chk("a_rdata", 32'(a_rdata), 32'(d));
    end else begin
      chk("a_rvalid_idle", 32'(a_rvalid), 32'd0);
      chk("a_rdata_idle", 32'(a_rdata), 32'd0);
    end
    if (qb.size() > 0) begin
      d = qb.pop_front();
      chk("b_rvalid", 32'(b_rvalid), 32'd1);
      chk("b_rdata", 32'(b_rdata), 32'(d));
    end else begin
      chk("b_rvalid_idle", 32'(b_rvalid), 32'd0);
      chk("b_rdata_idle", 32'(b_rdata), 32'd0);
    end
  endtask

  // One ARB cycle: check returns from the previous cycle, drive requests, check the grant path.
  task automatic cyc(input logic ar, input logic aw, input logic [3:0] aa, input logic [7:0] ad,
                     input logic br, input logic bw, input logic [3:0] ba, input logic [7:0] bd,
                     input logic exp_ag, input logic exp_bg);
    @(negedge clk);
    check_rv();
    a_req = ar; a_we = aw; a_addr = aa; a_din = ad;
    b_req = br; b_we = bw; b_addr = ba; b_din = bd;
    #1;
    chk("a_gnt", 32'(a_gnt), 32'(exp_ag));
    chk("b_gnt", 32'(b_gnt), 32'(exp_bg));
    chk("ram_en", 32'(ram_en), 32'(exp_ag | exp_bg));
    if (exp_ag) begin
      chk("ram_we_a", 32'(ram_we), 32'(aw));
      chk("ram_addr_a", 32'(ram_addr), 32'(aa));
      chk("ram_din_a", 32'(ram_din), 32'(ad));
      if (aw) shadow[aa] = ad; else qa.push_back(shadow[aa]);
    end else if (exp_bg) begin
      chk("ram_we_b", 32'(ram_we), 32'(bw));
      chk("ram_addr_b", 32'(ram_addr), 32'(ba));
      chk("ram_din_b", 32'(ram_din), 32'(bd));
      if (bw) shadow[ba] = bd; else qb.push_back(shadow[ba]);
    end
    $display("cycle t=%0t a_req=%b b_req=%b a_gnt=%b b_gnt=%b ram_addr=%h", $time, ar, br, a_gnt, b_gnt, ram_addr);
  endtask

  // Releases rst on the first negedge, then follows the DEPTH-cycle zero-fill.
  task automatic clear_phase();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      #1;
      chk("clr_busy", 32'(init_busy), 32'd1);
      chk("clr_en", 32'(ram_en), 32'd1);
      chk("clr_we", 32'(ram_we), 32'd1);
      chk("clr_addr", 32'(ram_addr), 32'(i));
      chk("clr_din", 32'(ram_din), 32'd0);
      chk("clr_a_gnt", 32'(a_gnt), 32'd0);
      chk("clr_b_gnt", 32'(b_gnt), 32'd0);
      chk("clr_a_rvalid", 32'(a_rvalid), 32'd0);
    end
    for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
    $display("clear sweep done t=%0t", $time);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
    ram_dout = 8'hEE;
    rst = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd5; a_din = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = 4'd0; b_din = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_en", 32'(ram_en), 32'd0);
    chk("rst_a_gnt", 32'(a_gnt), 32'd0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);

    // Clear with A's read of 5 pending, granted in first ARB cycle
    clear_phase();
    cyc(1, 0, 4'd5, 8'h00, 0, 0, 4'd0, 8'h00, 1, 0);
    chk("arb_busy", 32'(init_busy), 32'd0);
    cyc(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);

    // A write then read
    cyc(1, 1, 4'd3, 8'hA0, 0, 0, 4'd0, 8'h00, 1, 0);
    cyc(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00, 1, 0);
    cyc(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);

    // B alone, writes then back-to-back reads; A's idle inputs carry junk
    cyc(0, 1, 4'hF, 8'hFF, 1, 1, 4'd1, 8'h11, 0, 1);
    cyc(0, 1, 4'hF, 8'hFF, 1, 1, 4'd2, 8'h22, 0, 1);
    cyc(0, 1, 4'hF, 8'hFF, 1, 1, 4'd3, 8'h33, 0, 1);
    cyc(0, 1, 4'hF, 8'hFF, 1, 1, 4'd4, 8'h44, 0, 1);
    cyc(0, 1, 4'hF, 8'hFF, 1, 0, 4'd1, 8'h00, 0, 1);
    cyc(0, 1, 4'hF, 8'hFF, 1, 0, 4'd2, 8'h00, 0, 1);
    cyc(0, 1, 4'hF, 8'hFF, 1, 0, 4'd3, 8'h00, 0, 1);
    cyc(0, 1, 4'hF, 8'hFF, 1, 0, 4'd4, 8'h00, 0, 1);
    cyc(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);

    // A read of 3 granted, then rst lands before its return edge
    cyc(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00, 1, 0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(init_busy), 32'd1);
    chk("midrst_en", 32'(ram_en), 32'd0);
    chk("midrst_a_gnt", 32'(a_gnt), 32'd0);
    qa.delete();
    a_req = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_a_rvalid", 32'(a_rvalid), 32'd0);
    clear_phase();

    // Sustained contention straight after clear: A first, then alternating
    cyc(1, 0, 4'd3, 8'h00, 1, 1, 4'd7, 8'h55, 1, 0);
    cyc(1, 0, 4'd3, 8'h00, 1, 1, 4'd7, 8'h55, 0, 1);
    cyc(1, 0, 4'd3, 8'h00, 1, 1, 4'd7, 8'h55, 1, 0);
    cyc(1, 0, 4'd3, 8'h00, 1, 1, 4'd7, 8'h55, 0, 1);
    cyc(0, 0, 4'd0, 8'h00, 1, 0, 4'd7, 8'h00, 0, 1);
    cyc(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);
    cyc(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
